// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   register offsets within the MMIO window, CTRL bit positions,
//   the transmitter state encoding and an even-parity helper.
//   Optional feature macro (consumed by mmio_uart_tx): MMIO_UART_PARITY_EN.
package mmio_uart_pkg;

  // Byte offsets from BASE_ADDR
  localparam logic [31:0] TXDATA_OFS = 32'h0;
  localparam logic [31:0] CTRL_OFS   = 32'h4;

  // CTRL register bit positions
  localparam int CTRL_TX_EN_BIT   = 0;  // persistent enable
  localparam int CTRL_FLUSH_BIT   = 1;  // pulse: discard queued bytes
  localparam int CTRL_CLR_OVF_BIT = 2;  // pulse: clear sticky overflow

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with an explicit occupancy counter, so full/empty
//   never depend on pointer comparison. Pointers wrap modulo DEPTH
//   (DEPTH must be a power of two, >= 2). The head entry is presented
//   combinationally on o_rdata and is consumed by i_pop.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   i_push, i_wdata  write request and data
//   i_pop            consume head entry (ignored when empty)
//   i_flush          discard all entries; takes priority over push/pop
//   o_rdata          head entry
//   o_full, o_empty  occupancy flags
//   o_level          occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full   = (r_level == LW'(DEPTH));
  assign o_empty  = (r_level == '0);
  assign o_level  = r_level;
  assign o_rdata  = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter on the core's I/O store bus. Stores to
//   BASE_ADDR+0 (TXDATA) queue a byte; stores to BASE_ADDR+4 (CTRL) set
//   tx_en and issue flush / clear-overflow pulses. Queued bytes are sent
//   LSB first as START, 8 DATA, [PARITY], STOP; every bit lasts
//   CLKS_PER_BIT clocks.
//   Optional feature: define MMIO_UART_PARITY_EN to insert an even-parity
//   bit after the data bits (11 bit times per frame instead of 10).
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   io_write_addr/en/data             store bus from the core
//   uart_tx                           serial line, idle high
//   tx_busy                           a frame is in flight
//   fifo_full/fifo_empty/fifo_level   TX queue status
//   overflow                          sticky: a TXDATA byte was dropped
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [31:0]                   io_write_addr,
  input  logic                          io_write_en,
  input  logic [31:0]                   io_write_data,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  // ---------------- register decode ----------------
  logic       w_sel_txdata;
  logic       w_sel_ctrl;
  logic       w_flush;
  logic       w_clr_ovf;
  logic       w_drop;
  logic       w_pop;
  logic [7:0] w_fifo_rdata;
  logic       w_unused_data;
  logic       r_tx_en;
  logic       r_overflow;

  assign w_sel_txdata  = io_write_en && (io_write_addr == (BASE_ADDR + TXDATA_OFS));
  assign w_sel_ctrl    = io_write_en && (io_write_addr == (BASE_ADDR + CTRL_OFS));
  assign w_flush       = w_sel_ctrl && io_write_data[CTRL_FLUSH_BIT];
  assign w_clr_ovf     = w_sel_ctrl && io_write_data[CTRL_CLR_OVF_BIT];
  assign w_drop        = w_sel_txdata && fifo_full && !w_pop;
  assign w_unused_data = ^io_write_data[31:8];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_en    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_sel_ctrl) r_tx_en <= io_write_data[CTRL_TX_EN_BIT];
      // A drop wins over a clear so no lost byte goes unreported.
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_sel_txdata),
    .i_wdata (io_write_data[7:0]),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_rdata (w_fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  // ---------------- transmitter FSM ----------------
  tx_state_t  r_state, w_state_next;
  logic [BW-1:0] r_baud, w_baud_next;
  logic [2:0] r_bit_idx, w_bit_next;
  logic [7:0] r_shift, w_shift_next;
  logic       r_tx, w_tx_next;
  logic       w_baud_done;
`ifdef MMIO_UART_PARITY_EN
  logic       r_parity, w_parity_next;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
`ifdef MMIO_UART_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = r_baud + 1'b1;
    w_bit_next    = r_bit_idx;
    w_shift_next  = r_shift;
    w_pop         = 1'b0;
    w_tx_next     = 1'b1;
    w_baud_done   = (r_baud == BAUD_LAST);
`ifdef MMIO_UART_PARITY_EN
    w_parity_next = r_parity;
`endif

    case (r_state)
      ST_IDLE: begin
        w_baud_next = '0;
        if (!fifo_empty && r_tx_en) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_rdata;
          w_state_next = ST_START;
`ifdef MMIO_UART_PARITY_EN
          w_parity_next = even_parity(w_fifo_rdata);
`endif
        end
      end
      ST_START: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          w_bit_next   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_baud_next  = '0;
        w_state_next = ST_IDLE;
      end
    endcase

    // Line level is registered alongside the state so each bit lasts
    // exactly CLKS_PER_BIT cycles and the output is glitch-free.
    case (w_state_next)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = w_shift_next[0];
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: w_tx_next = w_parity_next;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign uart_tx = r_tx;
  assign tx_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
//   Build with MMIO_UART_PARITY_EN defined to also exercise the parity bit.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
`ifdef MMIO_UART_PARITY_EN
  localparam int          FB    = 11;
`else
  localparam int          FB    = 10;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] io_write_addr = '0;
  logic        io_write_en = 1'b0;
  logic [31:0] io_write_data = '0;
  logic        uart_tx;
  logic        tx_busy;
  logic        fifo_full;
  logic        fifo_empty;
  logic [4:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .io_write_addr (io_write_addr),
    .io_write_en   (io_write_en),
    .io_write_data (io_write_data),
    .uart_tx       (uart_tx),
    .tx_busy       (tx_busy),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_level    (fifo_level),
    .overflow      (overflow)
  );

  // One store; returns on the negedge after the capturing posedge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    io_write_addr = a;
    io_write_data = d;
    io_write_en   = 1'b1;
    @(negedge clk);
    io_write_en   = 1'b0;
    $display("store addr=%08h data=%08h", a, d);
  endtask

  // Serial receiver: waits for a start bit, samples mid-bit.
  task automatic rx_frame(output logic [7:0] data, output logic par,
                          output logic framing_ok, output logic timeout);
    int waited;
    waited = 0;
    data = '0; par = 1'b0; framing_ok = 1'b0; timeout = 1'b0;
    while (uart_tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (uart_tx !== 1'b0) begin
      timeout = 1'b1;
      return;
    end
    repeat (2) @(negedge clk);
    framing_ok = (uart_tx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      data[i] = uart_tx;
    end
`ifdef MMIO_UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    par = uart_tx;
`endif
    repeat (CPB) @(negedge clk);
    framing_ok = framing_ok && (uart_tx === 1'b1);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got %b want 1", uart_tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b want 0", tx_busy); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got %b want 0", fifo_full); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_fifo_empty got %b want 1", fifo_empty); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_fifo_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    $display("test_reset done");
  endtask

  task automatic test_single_frame;
    logic [7:0] exp;
    exp = 8'h55;
    do_store(BASE, 32'h55);
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL frame_level_after_store got %0d want 1", fifo_level); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_idle_before_pop got %b want 1", uart_tx); end
    @(negedge clk);  // t0: first start-bit cycle
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL frame_start_latency got %b want 0", uart_tx); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL frame_busy_start got %b want 1", tx_busy); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL frame_level_after_pop got %0d want 0", fifo_level); end
    @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL frame_start_hold got %b want 0", uart_tx); end
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      checks++;
      if (uart_tx !== exp[i]) begin errors++; $display("FAIL frame_data_bit%0d got %b want %b", i, uart_tx, exp[i]); end
    end
`ifdef MMIO_UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL frame_parity_55 got %b want 0", uart_tx); end
`endif
    repeat (CPB) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_stop got %b want 1", uart_tx); end
    repeat (CPB - 2) @(negedge clk);  // t0 + FB*CPB - 1
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL frame_busy_last_cycle got %b want 1", tx_busy); end
    @(negedge clk);                   // t0 + FB*CPB
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end got %b want 0", tx_busy); end
    $display("test_single_frame byte=%02h done", exp);
  endtask

  task automatic test_decode_ignore;
    logic stayed_idle;
    do_store(BASE + 32'd8, 32'hAA);
    do_store(32'h0000_0100, 32'h55);
    do_store(BASE + 32'd1, 32'h0F);
    stayed_idle = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) stayed_idle = 1'b0;
    end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL decode_level got %0d want 0", fifo_level); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL decode_empty got %b want 1", fifo_empty); end
    checks++; if (stayed_idle !== 1'b1) begin errors++; $display("FAIL decode_line_idle got %b want 1", stayed_idle); end
    $display("test_decode_ignore done");
  endtask

  task automatic test_overflow_drain;
    logic [7:0] d, exp;
    logic       p, ok, to;
    do_store(BASE + 32'd4, 32'h0);  // tx_en off
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      io_write_addr = BASE;
      io_write_data = 32'h10 + i;
      io_write_en   = 1'b1;
      @(negedge clk);
    end
    io_write_en = 1'b0;
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", fifo_full); end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL ovf_no_tx got %b want 0", tx_busy); end
    // CTRL=101 (tx_en, clr_ovf), then a TXDATA store while full on the pop cycle
    io_write_addr = BASE + 32'd4; io_write_data = 32'h5; io_write_en = 1'b1;
    @(negedge clk);
    io_write_addr = BASE; io_write_data = 32'h2F;
    @(negedge clk);
    io_write_en = 1'b0;
    $display("store ctrl=101 then txdata=2f on pop cycle");
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", overflow); end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_push_pop_level got %0d want 16", fifo_level); end
    for (int i = 0; i < 17; i++) begin
      exp = (i < 16) ? 8'(8'h10 + i) : 8'h2F;
      rx_frame(d, p, ok, to);
      checks++;
      if (to || d !== exp || !ok) begin
        errors++;
        $display("FAIL drain_frame%0d got %02h ok=%b to=%b want %02h", i, d, ok, to, exp);
      end
      $display("rx frame %0d byte=%02h", i, d);
    end
    repeat (4) @(negedge clk);
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_flush;
    logic quiet;
    repeat (8) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      io_write_addr = BASE; io_write_data = 32'h3C + i; io_write_en = 1'b1;
      @(negedge clk);
    end
    io_write_addr = BASE + 32'd4; io_write_data = 32'h3;  // flush + tx_en
    @(negedge clk);
    io_write_en = 1'b0;
    $display("store 6 bytes then ctrl=011");
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d want 0", fifo_level); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL flush_frame_kept got %b want 1", tx_busy); end
    repeat (FB * CPB - 6) @(negedge clk);
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL flush_frame_len_early got %b want 1", tx_busy); end
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL flush_frame_end got %b want 0", tx_busy); end
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL flush_no_more_frames got %b want 1", quiet); end
    $display("test_flush done");
  endtask

  task automatic test_back_to_back;
    int  cnt;
    logic seen_high;
    @(negedge clk);
    io_write_addr = BASE; io_write_data = 32'hFF; io_write_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    io_write_en = 1'b0;
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL b2b_first_start got %b want 0", uart_tx); end
    cnt = 0; seen_high = 1'b0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (uart_tx === 1'b1) seen_high = 1'b1;
      else if (seen_high) break;
    end
    checks++; if (cnt != FB * CPB + 1) begin errors++; $display("FAIL b2b_start_spacing got %0d want %0d", cnt, FB * CPB + 1); end
    repeat (FB * CPB + 5) @(negedge clk);
    $display("test_back_to_back spacing=%0d", cnt);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    logic       p, ok, to;
    @(negedge clk);
    io_write_addr = BASE; io_write_data = 32'h00; io_write_en = 1'b1;
    @(negedge clk);
    io_write_data = 32'h12;
    @(negedge clk);
    io_write_data = 32'h34;
    @(negedge clk);
    io_write_en = 1'b0;
    repeat (6) @(negedge clk);  // inside DATA bits of byte 00
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL rst_mid_in_data got %b want 0", uart_tx); end
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL rst_mid_level_before got %0d want 2", fifo_level); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_mid_uart_tx got %b want 1", uart_tx); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_mid_level got %0d want 0", fifo_level); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", tx_busy); end
    @(negedge clk);
    rstn = 1'b1;
    do_store(BASE, 32'hA5);
    rx_frame(d, p, ok, to);
    checks++;
    if (to || d !== 8'hA5 || !ok) begin errors++; $display("FAIL rst_mid_recover got %02h ok=%b to=%b want a5", d, ok, to); end
    repeat (6) @(negedge clk);
    $display("test_reset_mid_frame rx=%02h", d);
  endtask

`ifdef MMIO_UART_PARITY_EN
  task automatic test_parity;
    logic [7:0] d;
    logic       p, ok, to;
    do_store(BASE, 32'h07);
    rx_frame(d, p, ok, to);
    checks++;
    if (to || d !== 8'h07 || p !== 1'b1 || !ok) begin errors++; $display("FAIL parity_07 got %02h p=%b ok=%b want 07 p=1", d, p, ok); end
    repeat (6) @(negedge clk);
    do_store(BASE, 32'h03);
    rx_frame(d, p, ok, to);
    checks++;
    if (to || d !== 8'h03 || p !== 1'b0 || !ok) begin errors++; $display("FAIL parity_03 got %02h p=%b ok=%b want 03 p=0", d, p, ok); end
    repeat (6) @(negedge clk);
    $display("test_parity done");
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_decode_ignore();
    test_overflow_drain();
    test_flush();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef MMIO_UART_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
